// File: rtl/instr_sequencer_if.sv
// Instruction-memory read channel between instr_sequencer (master) and memory (slave).
// Read data is valid in the same cycle that imem_ack is high.
interface instr_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: IDLE -> FETCH -> EXEC -> (FETCH | HALTED), owns pc and ir.
// Optional retired-instruction counter enabled by macro INSTR_SEQUENCER_INSTRET_EN.
module instr_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    instr_sequencer_if.master   imem,
    output logic [31:0]         ir,
    input  logic                dec_wwe,
    input  logic                dec_halt,
    input  logic                take_branch,
    input  logic [31:0]         dec_pc_imm,
    output logic                rf_we,
    output logic [31:0]         pc,
    output logic                halted,
    output logic [1:0]          state
`ifdef INSTR_SEQUENCER_INSTRET_EN
    ,
    output logic [31:0]         instret
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } seqState_t;

    seqState_t   curState;
    seqState_t   nextState;
    logic [31:0] pcNext;
    logic        fetchDone;

    assign fetchDone = (curState == FETCH) && imem.imem_ack;

    always_ff @(posedge clk) begin
        if (reset) curState <= IDLE;
        else       curState <= nextState;
    end

    always_comb begin
        nextState = curState;
        case (curState)
            IDLE:    if (run) nextState = FETCH;
            FETCH:   if (imem.imem_ack) nextState = EXEC;
            EXEC:    nextState = dec_halt ? HALTED : FETCH;
            HALTED:  if (run) nextState = FETCH;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        imem.imem_req = (curState == FETCH);
        halted        = (curState == HALTED);
        rf_we         = (curState == EXEC) && dec_wwe && !dec_halt;
    end

    assign imem.imem_addr = pc;
    assign state          = curState;

    // Halt overrides a taken branch; targets are forced word-aligned.
    always_comb begin
        pcNext = pc + 32'd4;
        if (take_branch && !dec_halt) pcNext = dec_pc_imm & ~32'd3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
            ir <= '0;
        end else begin
            if (fetchDone)          ir <= imem.imem_rdata;
            if (curState == EXEC)   pc <= pcNext;
        end
    end

`ifdef INSTR_SEQUENCER_INSTRET_EN
    always_ff @(posedge clk) begin
        if (reset)                 instret <= '0;
        else if (curState == EXEC) instret <= instret + 32'd1;
    end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed vector table, random run against a
// behavioural model, and hand-written reset / wrap / counter sequences.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, ack, wwe, hlt, br;
    logic [31:0] rdata, imm;

    logic [31:0] irA, pcA, irB, pcB;
    logic        rfA, hlA, rfB, hlB;
    logic [1:0]  stA, stB;
`ifdef INSTR_SEQUENCER_INSTRET_EN
    logic [31:0] icA, icB;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_sequencer_if ifA ();
    instr_sequencer_if ifB ();
    assign ifA.imem_ack   = ack;
    assign ifA.imem_rdata = rdata;
    assign ifB.imem_ack   = ack;
    assign ifB.imem_rdata = rdata;

    instr_sequencer #(.RESET_PC(32'h00000000)) dutA (
        .clk(clk), .reset(reset), .run(run), .imem(ifA), .ir(irA),
        .dec_wwe(wwe), .dec_halt(hlt), .take_branch(br), .dec_pc_imm(imm),
        .rf_we(rfA), .pc(pcA), .halted(hlA), .state(stA)
`ifdef INSTR_SEQUENCER_INSTRET_EN
        , .instret(icA)
`endif
    );

    instr_sequencer #(.RESET_PC(32'hFFFFFFFC)) dutB (
        .clk(clk), .reset(reset), .run(run), .imem(ifB), .ir(irB),
        .dec_wwe(wwe), .dec_halt(hlt), .take_branch(br), .dec_pc_imm(imm),
        .rf_we(rfB), .pc(pcB), .halted(hlB), .state(stB)
`ifdef INSTR_SEQUENCER_INSTRET_EN
        , .instret(icB)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic setIn(input logic r, input logic rn, input logic a, input logic [31:0] rd,
                         input logic w, input logic h, input logic b, input logic [31:0] im);
        reset = r; run = rn; ack = a; rdata = rd; wwe = w; hlt = h; br = b; imm = im;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, rn, a;
        logic [31:0] rd;
        logic        w, h, b;
        logic [31:0] im;
        logic [1:0]  eSt;
        logic [31:0] ePc, eIr;
        logic        eReq, eRf, eHl;
    } vec_t;

    vec_t tbl[16];

    // Reference model: the sequencer's observable architectural state.
    int          mPhase;   // 0 idle, 1 waiting for instruction, 2 executing, 3 stopped
    logic [31:0] mPc, mIr, mCnt;

    task automatic modelReset(input logic [31:0] rpc);
        mPhase = 0; mPc = rpc; mIr = 32'h0; mCnt = 32'h0;
    endtask

    task automatic modelEdge();
        if (reset) begin
            modelReset(32'h0);
        end else if (mPhase == 0 || mPhase == 3) begin
            if (run) mPhase = 1;
        end else if (mPhase == 1) begin
            if (ack) begin mIr = rdata; mPhase = 2; end
        end else begin
            mCnt = mCnt + 1;
            if (hlt) begin
                mPc = mPc + 4; mPhase = 3;
            end else begin
                mPc = br ? {imm[31:2], 2'b00} : mPc + 4;
                mPhase = 1;
            end
        end
    endtask

    task automatic modelCheck();
        chk("rnd.state",  {30'b0, stA}, mPhase);
        chk("rnd.pc",     pcA, mPc);
        chk("rnd.addr",   ifA.imem_addr, mPc);
        chk("rnd.ir",     irA, mIr);
        chk("rnd.req",    {31'b0, ifA.imem_req}, (mPhase == 1) ? 1 : 0);
        chk("rnd.halted", {31'b0, hlA}, (mPhase == 3) ? 1 : 0);
        chk("rnd.rf_we",  {31'b0, rfA}, (mPhase == 2 && wwe && !hlt) ? 1 : 0);
`ifdef INSTR_SEQUENCER_INSTRET_EN
        chk("rnd.instret", icA, mCnt);
`endif
    endtask

    initial begin
        tbl[0]  = '{1'b0,1'b0,1'b1,32'h99,      1'b0,1'b0,1'b0,32'h0,  2'd0,32'h0, 32'h0,      1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b1,1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,  2'd0,32'h0, 32'h0,      1'b0,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b0,1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,  2'd1,32'h0, 32'h0,      1'b1,1'b0,1'b0};
        tbl[3]  = '{1'b0,1'b0,1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,  2'd1,32'h0, 32'h0,      1'b1,1'b0,1'b0};
        tbl[4]  = '{1'b0,1'b0,1'b1,32'h000A0043,1'b0,1'b0,1'b0,32'h0,  2'd1,32'h0, 32'h0,      1'b1,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,1'b0,32'h0,  2'd2,32'h0, 32'hA0043,  1'b0,1'b1,1'b0};
        tbl[6]  = '{1'b0,1'b0,1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,  2'd1,32'h4, 32'hA0043,  1'b1,1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b0,1'b1,32'h111,     1'b0,1'b0,1'b0,32'h0,  2'd1,32'h4, 32'hA0043,  1'b1,1'b0,1'b0};
        tbl[8]  = '{1'b0,1'b0,1'b0,32'h0,       1'b0,1'b0,1'b0,32'h13, 2'd2,32'h4, 32'h111,    1'b0,1'b0,1'b0};
        tbl[9]  = '{1'b0,1'b0,1'b1,32'h222,     1'b0,1'b0,1'b0,32'h0,  2'd1,32'h8, 32'h111,    1'b1,1'b0,1'b0};
        tbl[10] = '{1'b0,1'b0,1'b0,32'h0,       1'b1,1'b1,1'b1,32'h13, 2'd2,32'h8, 32'h222,    1'b0,1'b0,1'b0};
        tbl[11] = '{1'b0,1'b0,1'b1,32'hDEADBEEF,1'b0,1'b0,1'b0,32'h0,  2'd3,32'hC, 32'h222,    1'b0,1'b0,1'b1};
        tbl[12] = '{1'b0,1'b1,1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,  2'd3,32'hC, 32'h222,    1'b0,1'b0,1'b1};
        tbl[13] = '{1'b0,1'b0,1'b1,32'h555,     1'b0,1'b0,1'b0,32'h0,  2'd1,32'hC, 32'h222,    1'b1,1'b0,1'b0};
        tbl[14] = '{1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,1'b1,32'h13, 2'd2,32'hC, 32'h555,    1'b0,1'b1,1'b0};
        tbl[15] = '{1'b0,1'b0,1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,  2'd1,32'h10,32'h555,    1'b1,1'b0,1'b0};

        setIn(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        step();

        for (int i = 0; i < 16; i++) begin
            setIn(tbl[i].rst, tbl[i].rn, tbl[i].a, tbl[i].rd, tbl[i].w, tbl[i].h, tbl[i].b, tbl[i].im);
            #1;
            chk($sformatf("vec%0d.state", i),  {30'b0, stA}, {30'b0, tbl[i].eSt});
            chk($sformatf("vec%0d.pc", i),     pcA, tbl[i].ePc);
            chk($sformatf("vec%0d.addr", i),   ifA.imem_addr, tbl[i].ePc);
            chk($sformatf("vec%0d.ir", i),     irA, tbl[i].eIr);
            chk($sformatf("vec%0d.req", i),    {31'b0, ifA.imem_req}, {31'b0, tbl[i].eReq});
            chk($sformatf("vec%0d.rf_we", i),  {31'b0, rfA}, {31'b0, tbl[i].eRf});
            chk($sformatf("vec%0d.halted", i), {31'b0, hlA}, {31'b0, tbl[i].eHl});
            step();
        end

        // Randomised run against the model
        setIn(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        modelReset(32'h0);
        for (int c = 0; c < 3000; c++) begin
            setIn($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 1) == 1, $urandom);
            #1;
            modelCheck();
            @(posedge clk);
            modelEdge();
            #1;
        end

        // RESET_PC near the top of the address space; spurious acks in IDLE/HALTED
        setIn(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        setIn(1'b0, 1'b0, 1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("wrap.idle_ir", irB, 32'h0);
        chk("wrap.idle_pc", pcB, 32'hFFFFFFFC);
        setIn(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("wrap.addr", ifB.imem_addr, 32'hFFFFFFFC);
        chk("wrap.req",  {31'b0, ifB.imem_req}, 32'h1);
        setIn(1'b0, 1'b0, 1'b1, 32'h13, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("wrap.exec_state", {30'b0, stB}, 32'h2);
        chk("wrap.exec_ir", irB, 32'h13);
        setIn(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("wrap.pc", pcB, 32'h0);
        chk("wrap.fetch_state", {30'b0, stB}, 32'h1);
        setIn(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        setIn(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        chk("wrap.halt_pc", pcB, 32'h4);
        setIn(1'b0, 1'b0, 1'b1, 32'hBAD, 1'b0, 1'b0, 1'b1, 32'h40);
        step();
        chk("wrap.halted_ir", irB, 32'h20);
        chk("wrap.halted_pc", pcB, 32'h4);
        chk("wrap.halted_state", {30'b0, stB}, 32'h3);

        // Reset coinciding with an acknowledged fetch
        setIn(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        setIn(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        setIn(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("rstfetch.pre_req", {31'b0, ifA.imem_req}, 32'h1);
        setIn(1'b1, 1'b0, 1'b1, 32'hABCD, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("rstfetch.state", {30'b0, stA}, 32'h0);
        chk("rstfetch.req",   {31'b0, ifA.imem_req}, 32'h0);
        chk("rstfetch.ir",    irA, 32'h0);
        chk("rstfetch.pc",    pcA, 32'h0);
        chk("rstfetch.pcB",   pcB, 32'hFFFFFFFC);

`ifdef INSTR_SEQUENCER_INSTRET_EN
        setIn(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("instret.zero", icA, 32'h0);
        for (int k = 0; k < 3; k++) begin
            setIn(1'b0, 1'b0, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0);
            step();
            setIn(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
            step();
        end
        chk("instret.three", icA, 32'h3);
        setIn(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("instret.reset", icA, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter: RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 run  input  1  start from IDLE or resume from HALTED; sampled only in those states.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  fetch address; equals pc.
REQ-007 imem_ack  input  1  memory accepted the request; imem_rdata valid in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 ir  output  32  latched instruction register, drives the decoder's iReg.
REQ-010 dec_wwe  input  1  decoder register-write enable for ir.
REQ-011 dec_halt  input  1  decoder halt indication for ir.
REQ-012 take_branch  input  1  datapath branch/jump-taken result for ir.
REQ-013 dec_pc_imm  input  32  decoder jump/branch target for ir.
REQ-014 rf_we  output  1  gated register-file write enable.
REQ-015 pc  output  32  current program counter.
REQ-016 halted  output  1  high while in HALTED.
REQ-017 state  output  2  FSM state encoding: IDLE=0, FETCH=1, EXEC=2, HALTED=3.
REQ-018 instret  output  32  retired-instruction count; present only per REQ-033.

Function
REQ-019 The FSM shall have exactly four states: IDLE, FETCH, EXEC, HALTED.
REQ-020 IDLE: when run=1, next state is FETCH; otherwise the FSM stays in IDLE.
REQ-021 FETCH: imem_req=1 and imem_addr=pc, held stable until imem_ack=1 is sampled.
REQ-022 FETCH with imem_ack=1: ir<=imem_rdata, next state EXEC, and imem_req=0 in the following cycle.
REQ-023 Fetch latency: ack sampled in cycle N -> EXEC in cycle N+1 -> FETCH (re-request) in N+2.
REQ-024 EXEC lasts exactly one cycle; rf_we=dec_wwe & ~dec_halt, combinational, in EXEC only; rf_we=0 in all other states.
REQ-025 EXEC without halt: pc<=take_branch ? {dec_pc_imm[31:2],2'b00} : pc+4, and next state is FETCH.
REQ-026 EXEC with dec_halt=1: pc<=pc+4 (branch ignored), next state HALTED; halt has priority over take_branch.
REQ-027 HALTED: halted=1, imem_req=0; run=1 -> FETCH at the current pc.
REQ-028 pc+4 shall wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-029 imem_ack outside FETCH shall be ignored; ir and pc shall be unchanged.
REQ-030 ir shall change only on an acknowledged fetch.

Reset
REQ-031 With reset=1 at a clock edge: state=IDLE, pc=RESET_PC, ir=0, imem_req=0, rf_we=0, halted=0, instret=0, regardless of current state.
REQ-032 Reset mid-FETCH: imem_req=0 from the next cycle; a coincident imem_ack is discarded and ir stays 0.

Configuration
REQ-033 Macro INSTR_SEQUENCER_INSTRET_EN:
- Defined: instret port exists and increments by 1 (wrapping) on every EXEC cycle, halt included.
- Undefined: instret port and its counter are absent; all other behaviour is identical.

Verification
REQ-034 Reset, run=1, ack after 2 wait cycles with rdata=32'h000A0043 -> imem_addr=0 held for 3 cycles, ir=32'h000A0043, EXEC with rf_we=dec_wwe, then pc=4 and FETCH.
REQ-035 EXEC with take_branch=1, dec_pc_imm=32'h00000013 -> pc=32'h00000010; with take_branch=0 -> pc=old pc+4.
REQ-036 EXEC with dec_halt=1, dec_wwe=1, take_branch=1 at pc=8 -> rf_we=0, HALTED, halted=1, pc=12; run=1 -> FETCH at imem_addr=12.
REQ-037 RESET_PC=32'hFFFFFFFC, one non-branch instruction -> pc=0 after EXEC; spurious imem_ack in IDLE/HALTED leaves ir and pc unchanged.
REQ-038 Reset asserted while imem_req=1 with coincident ack -> next cycle state=IDLE, imem_req=0, ir=0, pc=RESET_PC; with INSTR_SEQUENCER_INSTRET_EN, 3 executed instructions -> instret=3, then 0 after reset.
